// File: rtl/debounce_pkg.sv
// Shared types for the debouncer family: the per-channel qualify state and counter sizing.
package debounce_pkg;

  typedef enum logic [1:0] {
    S_0       = 2'b00,
    S_MAYBE_1 = 2'b01,
    S_1       = 2'b10,
    S_MAYBE_0 = 2'b11
  } debounce_state_t;

  function automatic int cnt_width(input int ticks);
    return $clog2(ticks + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce lane: synchroniser, 4-state qualify FSM, registered level and edge strobes.
// Long-press detection is compiled in with DEBOUNCER_HOLD_EN.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int BOUNCE_TICKS = 10,
  parameter int SYNC_STAGES  = 2
`ifdef DEBOUNCER_HOLD_EN
  ,
  parameter int HOLD_TICKS   = 1000
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic i_bouncy,
  output logic o_level,
  output logic o_rise,
  output logic o_fall,
  output logic o_change_nxt
`ifdef DEBOUNCER_HOLD_EN
  ,
  output logic o_held
`endif
);

  localparam int CW = cnt_width(BOUNCE_TICKS);
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t LAST = cnt_t'(BOUNCE_TICKS - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  debounce_state_t        r_state, w_next_state;
  cnt_t                   r_cnt, w_next_cnt;
  logic                   r_level, r_rise, r_fall;
  logic                   w_s, w_level_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync[0] <= i_bouncy;
      for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  // A MAYBE state falls straight back the moment the input reverts.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    case (r_state)
      S_0: begin
        if (w_s) begin
          w_next_state = S_MAYBE_1;
          w_next_cnt   = '0;
        end
      end
      S_MAYBE_1: begin
        if (!w_s)               w_next_state = S_0;
        else if (r_cnt == LAST) w_next_state = S_1;
        else                    w_next_cnt   = r_cnt + cnt_t'(1);
      end
      S_1: begin
        if (!w_s) begin
          w_next_state = S_MAYBE_0;
          w_next_cnt   = '0;
        end
      end
      S_MAYBE_0: begin
        if (w_s)                w_next_state = S_1;
        else if (r_cnt == LAST) w_next_state = S_0;
        else                    w_next_cnt   = r_cnt + cnt_t'(1);
      end
      default: w_next_state = S_0;
    endcase
  end

  assign w_level_nxt = (w_next_state == S_1) || (w_next_state == S_MAYBE_0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_0;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      r_level <= w_level_nxt;
      r_rise  <= w_level_nxt & ~r_level;
      r_fall  <= ~w_level_nxt & r_level;
    end
  end

  assign o_level      = r_level;
  assign o_rise       = r_rise;
  assign o_fall       = r_fall;
  assign o_change_nxt = w_level_nxt ^ r_level;

`ifdef DEBOUNCER_HOLD_EN
  localparam int HW = cnt_width(HOLD_TICKS);
  typedef logic [HW-1:0] hold_t;
  localparam hold_t HOLD_MAX = hold_t'(HOLD_TICKS);

  hold_t r_hold;

  // Every entry into S_1 (including a glitch abort) restarts the long-press count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold <= '0;
    end else if ((w_next_state == S_1) && (r_state != S_1)) begin
      r_hold <= '0;
    end else if ((r_state == S_1) && (r_hold != HOLD_MAX)) begin
      r_hold <= r_hold + hold_t'(1);
    end
  end

  assign o_held = (r_state == S_1) && (r_hold == HOLD_MAX);
`endif

endmodule

// File: rtl/multi_debouncer.sv
// Bank of independent debounce channels with a shared registered any_change wake-up strobe.
// Define DEBOUNCER_HOLD_EN to add the per-channel long-press 'held' output.
module multi_debouncer
  import debounce_pkg::*;
#(
  parameter int N_CHANNELS   = 4,
  parameter int BOUNCE_TICKS = 10,
  parameter int SYNC_STAGES  = 2,
  parameter int HOLD_TICKS   = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CHANNELS-1:0] bouncy_in,
  output logic [N_CHANNELS-1:0] debounced_out,
  output logic [N_CHANNELS-1:0] rise,
  output logic [N_CHANNELS-1:0] fall,
  output logic                  any_change
`ifdef DEBOUNCER_HOLD_EN
  ,
  output logic [N_CHANNELS-1:0] held
`endif
);

  logic [N_CHANNELS-1:0] w_change;
  logic                  r_any;

  for (genvar i = 0; i < N_CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .BOUNCE_TICKS(BOUNCE_TICKS),
      .SYNC_STAGES (SYNC_STAGES)
`ifdef DEBOUNCER_HOLD_EN
      ,
      .HOLD_TICKS  (HOLD_TICKS)
`endif
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .i_bouncy    (bouncy_in[i]),
      .o_level     (debounced_out[i]),
      .o_rise      (rise[i]),
      .o_fall      (fall[i]),
      .o_change_nxt(w_change[i])
`ifdef DEBOUNCER_HOLD_EN
      ,
      .o_held      (held[i])
`endif
    );
  end

  // Built from next-state edges so it lands in the same cycle as rise/fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_any <= 1'b0;
    else     r_any <= |w_change;
  end

  assign any_change = r_any;

endmodule

// File: tb/tb_multi_debouncer.sv
// Self-checking bench for multi_debouncer: directed table, hand sequences and random stimulus vs a run-length model.
module tb_multi_debouncer;

  localparam int N      = 4;
  localparam int BOUNCE = 10;
  localparam int SYNC   = 2;
  localparam int HOLD   = 20;

  logic         clk;
  logic         rst;
  logic [N-1:0] bouncy_in;
  logic [N-1:0] debounced_out, rise, fall;
  logic         any_change;
`ifdef DEBOUNCER_HOLD_EN
  logic [N-1:0] held;
`endif

  multi_debouncer #(
    .N_CHANNELS  (N),
    .BOUNCE_TICKS(BOUNCE),
    .SYNC_STAGES (SYNC),
    .HOLD_TICKS  (HOLD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bouncy_in    (bouncy_in),
    .debounced_out(debounced_out),
    .rise         (rise),
    .fall         (fall),
    .any_change   (any_change)
`ifdef DEBOUNCER_HOLD_EN
    ,
    .held         (held)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: committed level plus length of the current run of disagreeing samples.
  logic [N-1:0] mL, mRise, mFall, mHeld, mPrevInS1;
  logic         mAny;
  int           mRun[N];
  int           mHoldT[N];
  logic [N-1:0] mHist[$];

  int riseCnt[N];
  int anyCnt;

  typedef struct {
    logic [N-1:0] raw;
    int           cycles;
    logic [N-1:0] expDeb;
  } vec_t;
  vec_t vecs[9];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic modelReset();
    mL = '0; mRise = '0; mFall = '0; mHeld = '0; mPrevInS1 = '0; mAny = 1'b0;
    for (int i = 0; i < N; i++) begin
      mRun[i] = 0;
      mHoldT[i] = 0;
    end
    mHist.delete();
    for (int k = 0; k < SYNC; k++) mHist.push_back('0);
  endtask

  task automatic modelStep(input logic [N-1:0] raw);
    logic [N-1:0] s;
    logic inS1;
    s = mHist.pop_front();
    mHist.push_back(raw);
    mRise = '0;
    mFall = '0;
    for (int i = 0; i < N; i++) begin
      if (s[i] != mL[i]) begin
        mRun[i]++;
        if (mRun[i] == BOUNCE + 1) begin
          mL[i] = ~mL[i];
          mRun[i] = 0;
          if (mL[i]) mRise[i] = 1'b1;
          else       mFall[i] = 1'b1;
        end
      end else begin
        mRun[i] = 0;
      end
      inS1 = mL[i] && (mRun[i] == 0);
      if (inS1 && mPrevInS1[i]) begin
        if (mHoldT[i] < HOLD) mHoldT[i]++;
      end else begin
        mHoldT[i] = 0;
      end
      mPrevInS1[i] = inS1;
      mHeld[i] = inS1 && (mHoldT[i] >= HOLD);
    end
    mAny = |(mRise | mFall);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) modelReset();
    else     modelStep(bouncy_in);
    #1;
    checkOutput("debounced_out", debounced_out, mL);
    checkOutput("rise", rise, mRise);
    checkOutput("fall", fall, mFall);
    checkOutput("any_change", any_change, mAny);
`ifdef DEBOUNCER_HOLD_EN
    checkOutput("held", held, mHeld);
`endif
    anyCnt += any_change;
    for (int i = 0; i < N; i++) riseCnt[i] += rise[i];
  endtask

  task automatic applyStimulus(input logic [N-1:0] raw, input int cycles);
    bouncy_in = raw;
    for (int c = 0; c < cycles; c++) tick();
  endtask

  task automatic applyReset(input logic [N-1:0] raw);
    bouncy_in = raw;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) tick();
    rst = 1'b0;
  endtask

  initial begin
    vecs[0] = '{raw: 4'h1, cycles: 5,  expDeb: 4'h0};
    vecs[1] = '{raw: 4'h0, cycles: 4,  expDeb: 4'h0};
    vecs[2] = '{raw: 4'h2, cycles: 1,  expDeb: 4'h0};
    vecs[3] = '{raw: 4'h0, cycles: 1,  expDeb: 4'h0};
    vecs[4] = '{raw: 4'h2, cycles: 2,  expDeb: 4'h0};
    vecs[5] = '{raw: 4'h0, cycles: 1,  expDeb: 4'h0};
    vecs[6] = '{raw: 4'h2, cycles: 12, expDeb: 4'h0};
    vecs[7] = '{raw: 4'h2, cycles: 1,  expDeb: 4'h2};
    vecs[8] = '{raw: 4'h2, cycles: 3,  expDeb: 4'h2};

    rst = 1'b1;
    bouncy_in = '0;
    modelReset();
    anyCnt = 0;
    for (int i = 0; i < N; i++) riseCnt[i] = 0;

    // Inputs high through reset must still fully qualify after release.
    applyReset(4'hF);
    checkOutput("reset_debounced", debounced_out, 4'h0);
    checkOutput("reset_any", any_change, 1'b0);
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 12) checkOutput("init_deb_early", debounced_out, 4'h0);
      if (k == 13) begin
        checkOutput("init_deb", debounced_out, 4'hF);
        checkOutput("init_rise", rise, 4'hF);
        checkOutput("init_any", any_change, 1'b1);
      end
      if (k == 14) begin
        checkOutput("init_rise_off", rise, 4'h0);
        checkOutput("init_any_off", any_change, 1'b0);
      end
    end

    // Glitch reject on ch0, bounce-then-settle on ch1.
    applyReset(4'h0);
    applyStimulus(4'h0, 4);
    anyCnt = 0;
    for (int i = 0; i < N; i++) riseCnt[i] = 0;
    for (int v = 0; v < 9; v++) begin
      applyStimulus(vecs[v].raw, vecs[v].cycles);
      checkOutput($sformatf("vec%0d_deb", v), debounced_out, vecs[v].expDeb);
      if (v == 1) checkOutput("glitch_any_cnt", anyCnt, 0);
    end
    checkOutput("glitch_rise0_cnt", riseCnt[0], 0);
    checkOutput("bounce_rise1_cnt", riseCnt[1], 1);
    checkOutput("bounce_any_cnt", anyCnt, 1);

    // Simultaneous fall on ch2 and rise on ch3.
    applyReset(4'h4);
    applyStimulus(4'h4, 16);
    checkOutput("simul_pre", debounced_out, 4'h4);
    bouncy_in = 4'h8;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 13) begin
        checkOutput("simul_fall", fall, 4'h4);
        checkOutput("simul_rise", rise, 4'h8);
        checkOutput("simul_any", any_change, 1'b1);
        checkOutput("simul_deb", debounced_out, 4'h8);
      end
      if (k == 14) checkOutput("simul_any_off", any_change, 1'b0);
    end

    // Asynchronous reset pulse between edges while ch0 is mid-qualification.
    applyReset(4'h0);
    applyStimulus(4'h0, 4);
    applyStimulus(4'h1, 8);
    #2 rst = 1'b1;
    #1;
    modelReset();
    checkOutput("async_deb", debounced_out, 4'h0);
    checkOutput("async_rise", rise, 4'h0);
    #1 rst = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      tick();
      if (k == 12) checkOutput("async_requal_early", debounced_out, 4'h0);
      if (k == 13) begin
        checkOutput("async_requal_deb", debounced_out, 4'h1);
        checkOutput("async_requal_rise", rise, 4'h1);
      end
    end

`ifdef DEBOUNCER_HOLD_EN
    // Long press on ch1, then a 3-cycle low glitch restarts the hold count.
    applyReset(4'h0);
    applyStimulus(4'h2, 13);
    checkOutput("hold_deb", debounced_out, 4'h2);
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 19) checkOutput("hold_early", held, 4'h0);
      if (k == 20) checkOutput("hold_set", held, 4'h2);
    end
    bouncy_in = 4'h0;
    for (int k = 1; k <= 26; k++) begin
      if (k == 4) bouncy_in = 4'h2;
      tick();
      if (k == 3) checkOutput("hold_clear", held, 4'h0);
      if (k == 25) checkOutput("hold_re_early", held, 4'h0);
      if (k == 26) checkOutput("hold_re_set", held, 4'h2);
    end
    checkOutput("hold_deb_kept", debounced_out, 4'h2);
`endif

    // Random phases with varying bounce density.
    applyReset(4'h0);
    for (int ph = 0; ph < 12; ph++) begin
      int den;
      den = (ph % 3 == 0) ? 4 : ((ph % 3 == 1) ? 16 : 48);
      for (int c = 0; c < 200; c++) begin
        logic [N-1:0] v;
        v = bouncy_in;
        for (int i = 0; i < N; i++)
          if ($urandom_range(den - 1, 0) == 0) v[i] = ~v[i];
        applyStimulus(v, 1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
